// File: rtl/mult_ctrl_pkg.sv
// Shared types and constants for the bit-serial multiplier sequencer.
package mult_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int MULT_N_DEFAULT = 8;

    // Cycles from start acceptance to the done pulse for the normal path.
    function automatic int mult_latency(input int n);
        return n + 32'sd2;
    endfunction

endpackage

// File: rtl/mult_ctrl_bitser.sv
// N-bit load/shift-right register presenting its LSB, plus a saturating
// bit counter flagging the final bit position.
module mult_ctrl_bitser
    import mult_ctrl_pkg::*;
#(
    parameter int N     = MULT_N_DEFAULT,
    parameter int CNT_W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [N-1:0] d,
    output logic         ser_bit,
    output logic         last
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    logic [N-1:0]     sr_r;
    logic [CNT_W-1:0] cnt_r;

    // Load resets the counter; each shift drops the LSB and counts up,
    // stopping at the last bit position so the counter never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_r  <= {N{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            sr_r  <= d;
            cnt_r <= {CNT_W{1'b0}};
        end else if (shift) begin
            sr_r <= {1'b0, sr_r[N-1:1]};
            if (cnt_r != CNT_LAST) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            sr_r  <= sr_r;
            cnt_r <= cnt_r;
        end
    end

    assign ser_bit = sr_r[0];
    assign last    = (cnt_r == CNT_LAST);

endmodule

// File: rtl/mult_serial_ctrl.sv
// Sequencer for the bit-serial shift-add multiplier datapath.
// Handshakes an operand pair, clears the datapath for one cycle, streams the
// multiplier LSB-first for N cycles and captures the 2N-bit product.
// Optional build macro: MULT_CTRL_ZERO_SKIP_EN -- a zero operand completes
// immediately with a zero result and never touches the datapath.
module mult_serial_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int N     = MULT_N_DEFAULT,
    parameter int CNT_W = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a_in,
    input  logic [N-1:0]   b_in,
    output logic           ready,
    output logic           busy,
    output logic           mult_rst,
    output logic [N-1:0]   mult_g,
    output logic           mult_e,
    input  logic [2*N-1:0] mult_o,
    output logic [2*N-1:0] result,
    output logic           done
);

    state_t         state_r;
    state_t         state_next_s;
    logic           accept_s;
    logic           skip_s;
    logic [N-1:0]   a_q_r;
    logic [2*N-1:0] result_r;
    logic [N-1:0]   mult_g_r;
    logic           ready_r;
    logic           busy_r;
    logic           done_r;
    logic           ser_bit_s;
    logic           last_s;

    // Multiplier shift register and bit counter; loaded on acceptance,
    // advanced on every RUN cycle.
    mult_ctrl_bitser #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_bitser (
        .clk     (clk),
        .rst     (rst),
        .load    (accept_s),
        .shift   (state_r == RUN),
        .d       (b_in),
        .ser_bit (ser_bit_s),
        .last    (last_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        skip_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
`ifdef MULT_CTRL_ZERO_SKIP_EN
                    if ((a_in == {N{1'b0}}) || (b_in == {N{1'b0}})) begin
                        skip_s       = 1'b1;
                        state_next_s = DONE;
                    end else begin
                        state_next_s = CLEAR;
                    end
`else
                    state_next_s = CLEAR;
`endif
                end else begin
                    state_next_s = IDLE;
                end
            end
            CLEAR: begin
                state_next_s = RUN;
            end
            RUN: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Operand latch, product capture and status flags registered from the
    // next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q_r    <= {N{1'b0}};
            result_r <= {(2*N){1'b0}};
            mult_g_r <= {N{1'b0}};
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                a_q_r <= a_in;
            end else begin
                a_q_r <= a_q_r;
            end

            if ((state_r == RUN) && last_s) begin
                result_r <= mult_o;
            end else if (skip_s) begin
                result_r <= {(2*N){1'b0}};
            end else begin
                result_r <= result_r;
            end

            mult_g_r <= (state_next_s == RUN) ? a_q_r : {N{1'b0}};
            ready_r  <= (state_next_s == IDLE);
            busy_r   <= (state_next_s == CLEAR) || (state_next_s == RUN);
            done_r   <= (state_next_s == DONE);
        end
    end

    // The datapath is held in reset alongside this block and for the single
    // CLEAR cycle, so its accumulator starts every product from zero.
    assign mult_rst = rst | (state_r == CLEAR);
    assign mult_e   = (state_r == RUN) ? ser_bit_s : 1'b0;
    assign mult_g   = mult_g_r;
    assign result   = result_r;
    assign ready    = ready_r;
    assign busy     = busy_r;
    assign done     = done_r;

endmodule

// File: tb/tb_mult_serial_ctrl.sv
// Self-checking bench for mult_serial_ctrl with a behavioural shift-add
// datapath attached. Expected products are plain a*b; expected latencies
// come from the cycle-level timing of the operation.
module tb_mult_serial_ctrl;
    import mult_ctrl_pkg::*;

    localparam int N = 8;
    localparam int W = 2 * N;
`ifdef MULT_CTRL_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic         ready;
    logic         busy;
    logic         mult_rst;
    logic [N-1:0] mult_g;
    logic         mult_e;
    logic [W-1:0] mult_o;
    logic [W-1:0] result;
    logic         done;

    int checks   = 0;
    int failures = 0;

    mult_serial_ctrl #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .ready    (ready),
        .busy     (busy),
        .mult_rst (mult_rst),
        .mult_g   (mult_g),
        .mult_e   (mult_e),
        .mult_o   (mult_o),
        .result   (result),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath: acc' = (acc + e*g*2^N) / 2; after N bits acc == g*b.
    logic [W-1:0] acc_r;
    logic [W:0]   sum_s;
    always_comb begin
        sum_s  = {1'b0, acc_r} + (mult_e ? {1'b0, mult_g, {N{1'b0}}} : {(W+1){1'b0}});
        mult_o = sum_s[W:1];
    end
    always @(posedge clk) begin
        if (mult_rst) acc_r <= {W{1'b0}};
        else          acc_r <= mult_o;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic scramble_operands;
        logic [31:0] r;
        r = $urandom; a_in = r[N-1:0];
        r = $urandom; b_in = r[N-1:0];
    endtask

    // Issue one operation at the current negedge and check latency/result.
    task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [W-1:0] exp);
        int exp_lat;
        int lat;
        bit seen;
        exp_lat = (ZS && ((a == {N{1'b0}}) || (b == {N{1'b0}}))) ? 1 : mult_latency(N);
        check_bit({name, "_ready"}, ready, 1'b1);
        start = 1'b1; a_in = a; b_in = b;
        seen = 1'b0; lat = 0;
        for (int k = 1; (k <= N + 5) && !seen; k++) begin
            tick;
            start = 1'b0;
            scramble_operands();
            if (done) begin seen = 1'b1; lat = k; end
        end
        check_int({name, "_latency"}, lat, exp_lat);
        check({name, "_result"}, result, exp);
        tick;
        check_bit({name, "_ready_after"}, ready, 1'b1);
        check_bit({name, "_done_after"}, done, 1'b0);
    endtask

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [N-1:0] bv;
        logic [N-1:0] ha [3];
        logic [N-1:0] hb [3];
        logic [W-1:0] hexp [3];
        logic [31:0]  r;
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        int dones;
        int hidx;

        vecs[0] = '{a: 8'd255, b: 8'd255, exp: 16'hFE01};
        vecs[1] = '{a: 8'd1,   b: 8'd128, exp: 16'h0080};
        vecs[2] = '{a: 8'd2,   b: 8'd3,   exp: 16'h0006};
        vecs[3] = '{a: 8'd200, b: 8'd100, exp: 16'h4E20};
        vecs[4] = '{a: 8'd17,  b: 8'd17,  exp: 16'h0121};
        vecs[5] = '{a: 8'd0,   b: 8'd77,  exp: 16'h0000};
        vecs[6] = '{a: 8'd91,  b: 8'd0,   exp: 16'h0000};

        rst = 1'b1; start = 1'b0; a_in = {N{1'b0}}; b_in = {N{1'b0}};

        // Reset state.
        tick; tick;
        check_bit("rst_mult_rst", mult_rst, 1'b1);
        rst = 1'b0;
        tick;
        check_bit("rst_ready", ready, 1'b1);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_mult_e", mult_e, 1'b0);
        check_bit("rst_mult_rst_released", mult_rst, 1'b0);
        check("rst_mult_g", {{N{1'b0}}, mult_g}, {W{1'b0}});
        check("rst_result", result, {W{1'b0}});

        // a=13, b=11 cycle by cycle, with stray starts at cycles 3 and 10.
        bv = 8'd11;
        start = 1'b1; a_in = 8'd13; b_in = bv;
        dones = 0;
        for (int c = 1; c <= 12; c++) begin
            tick;
            if (done) dones++;
            if (c == 1) begin
                check_bit("clr_mult_rst", mult_rst, 1'b1);
                check_bit("clr_busy", busy, 1'b1);
                check_bit("clr_ready", ready, 1'b0);
            end else if (c <= 9) begin
                check_bit("run_mult_e", mult_e, bv[c-2]);
                check("run_mult_g", {{N{1'b0}}, mult_g}, 16'd13);
                check_bit("run_mult_rst", mult_rst, 1'b0);
            end else if (c == 10) begin
                check_bit("op13_done", done, 1'b1);
                check("op13_result", result, 16'h008F);
                check("done_mult_g", {{N{1'b0}}, mult_g}, {W{1'b0}});
            end else begin
                check_bit("op13_ready_back", ready, 1'b1);
            end
            start = (c == 3) || (c == 10);
            scramble_operands();
        end
        check_int("op13_single_done", dones, 1);

        // Reset during RUN: no done, state back to IDLE, result cleared.
        start = 1'b1; a_in = 8'd13; b_in = 8'd11;
        dones = 0;
        for (int c = 1; c <= 15; c++) begin
            tick;
            if (done) dones++;
            if (c == 6) begin
                check_bit("midrst_ready", ready, 1'b1);
                check_bit("midrst_busy", busy, 1'b0);
                check("midrst_result", result, {W{1'b0}});
                check_bit("midrst_mult_rst", mult_rst, 1'b1);
            end
            rst = (c == 5);
            start = 1'b0;
        end
        check_int("midrst_no_done", dones, 0);
        run_op("after_rst_7x9", 8'd7, 8'd9, 16'h003F);

        // Table-driven vectors.
        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // start held high across three operations.
        ha[0] = 8'd2;   hb[0] = 8'd3;   hexp[0] = 16'h0006;
        ha[1] = 8'd200; hb[1] = 8'd100; hexp[1] = 16'h4E20;
        ha[2] = 8'd17;  hb[2] = 8'd17;  hexp[2] = 16'h0121;
        start = 1'b1; a_in = ha[0]; b_in = hb[0];
        hidx = 0;
        for (int c = 1; c <= 36; c++) begin
            tick;
            if (done) begin
                if (hidx < 3) begin
                    check_int("held_done_cycle", c, 10 + 11 * hidx);
                    check("held_result", result, hexp[hidx]);
                end else begin
                    check_int("held_extra_done", hidx + 1, 3);
                end
                hidx++;
            end
            scramble_operands();
            if (c == 11 || c == 22) begin
                check_bit("held_ready", ready, 1'b1);
                a_in = ha[c / 11];
                b_in = hb[c / 11];
            end
            start = (c <= 22);
        end
        check_int("held_done_count", hidx, 3);

        // Randomised operations against a*b.
        for (int i = 0; i < 40; i++) begin
            r = $urandom; ra = r[N-1:0];
            r = $urandom; rb = r[N-1:0];
            if (r[20:18] == 3'd0) ra = {N{1'b0}};
            if (r[23:21] == 3'd0) rb = {N{1'b0}};
            run_op("rand", ra, rb, {{N{1'b0}}, ra} * {{N{1'b0}}, rb});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard bound on simulation time.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
